pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Parametrised decode/control unit for the 5-stage pipeline; sits in ID and drives the ID/EXE control register directly.
- Successor to the single-cycle decoder. It adds:
  - registered Z/N status flags written by CMP;
  - conditional branch resolution (BNE/BEQ/BLT) in ID;
  - a multi-cycle MULT sequencer that stalls the front end;
  - full bubble insertion on hazard or flush.

Parameters:
- WORD_LEN, 32, operand width for CMP.
- OP_CODE_LEN, 6, opcode width.
- EXE_CMD_LEN, 4, EXE command width.
- MULT_CYCLES, 4, total cycles a MULT occupies EXE; legal range 1..16.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- op_code  in  OP_CODE_LEN  opcode of the instruction in ID
- hazard_detected  in  1  load-use hazard; insert bubble
- flush  in  1  taken branch/jump; kill the instruction in ID
- src1  in  WORD_LEN  first register operand (CMP)
- src2  in  WORD_LEN  second register operand (CMP)
- exe_cmd  out  EXE_CMD_LEN  registered EXE command
- branch_cmd  out  2  registered condition code (COND_JUMP/BNE/BEQ/BLT)
- branch_en  out  1  registered: instruction is a branch/jump
- branch_taken  out  1  registered: branch condition true
- jump_en  out  1  registered: unconditional jump
- is_imm, st_or_bne, wb_en, mem_r_en, mem_w_en  out  1 each  registered control bits
- mult_start  out  1  one-cycle pulse to the EXE multiplier
- stall  out  1  hold PC and IF/ID (sequencer busy)
- flag_z, flag_n  out  1  architectural status flags
- illegal_op  out  1  registered: opcode not decoded

Behaviour:
- Reset (async, rst_n=0): all registered outputs are 0; flags are 0; sequencer is IDLE with counter 0; stall=0.
- Latency: decode is registered, so outputs reflect op_code one edge after capture.
- Bubble: all control outputs, mult_start and illegal_op are 0 on the next edge. A bubble is inserted when any of these holds:
  - hazard_detected=1;
  - flush=1;
  - sequencer is BUSY.
  - During a bubble, flags are unchanged and no MULT starts.
- Priority: rst_n > flush > BUSY > hazard_detected > decode.
- Decode, base set:
  - ADD, SUB, AND, SLL: exe_cmd from the matching constant; wb_en=1.
  - ADDI: EXE_ADD, wb_en, is_imm.
  - LW: EXE_ADD, wb_en, is_imm, st_or_bne, mem_r_en.
  - SW: EXE_NO_OPERATION, is_imm, st_or_bne, mem_w_en.
  - CLR: EXE_CLR, wb_en, is_imm.
  - MOVI: EXE_MOVI, wb_en, is_imm.
- CMP:
  - All control outputs are 0.
  - At the edge: flag_z=(src1==src2); flag_n=signed(src1)<signed(src2).
  - The difference is computed at WORD_LEN+1 bits, so the result does not overflow.
- Branches: is_imm=1, branch_en=1, branch_cmd set, and branch_taken evaluated from the current registered flags:
  - BNE: taken = !flag_z.
  - BEQ: taken = flag_z.
  - BLT: taken = flag_n.
  - JMP: branch_taken=1, jump_en=1.
- CMP then branch in the next cycle: the flags are already updated at the separating edge, so no forwarding is needed.
- MULT, sequencer with states IDLE and BUSY:
  - IDLE + MULT accepted: on the next edge, exe_cmd=EXE_MULT, wb_en=1, mult_start=1.
  - If MULT_CYCLES>1: go to BUSY with counter=MULT_CYCLES-1.
  - BUSY: stall=1 (decoded from the state register); counter decrements each edge; at 1, go to IDLE next edge.
  - Total stall is MULT_CYCLES-1 cycles.
  - MULT_CYCLES=1: BUSY is never entered.
- flush during BUSY: ignored. EXE owns the in-flight MULT; the sequencer completes.
- Unknown opcode: bubble outputs, illegal_op=1 for one cycle, flags unchanged.
- Reset mid-MULT: immediate return to IDLE; stall drops asynchronously.

Optional Feature:
- Macro CTRL_EXT_OPS_EN.
- Defined: OR, NOR, XOR, SLA, SRA, SRL (wb_en=1) and SUBI (EXE_SUB, wb_en, is_imm) are decoded.
- Undefined: these opcodes take the unknown-opcode path (bubble plus illegal_op pulse).

Decomposition:
- Shared package/defines: OP_* opcode constants, EXE_* commands, COND_* codes, OP_CODE_LEN, EXE_CMD_LEN, WORD_LEN.
- Sub-module ctrl_mult_seq: IDLE/BUSY FSM, counter and stall, parametrised by MULT_CYCLES. Decode, flags and the output register stay in the top module.

Test Plan:
- Reset with op_code=OP_ADD held; release rst_n -> first edge gives exe_cmd=EXE_ADD, wb_en=1; all outputs 0 during reset.
- CMP src1=5, src2=7 -> flag_n=1, flag_z=0. Next cycle BLT -> branch_taken=1. CMP -3,-3 -> flag_z=1; then BNE -> branch_taken=0.
- MULT with MULT_CYCLES=4 -> mult_start pulses one cycle; stall high exactly 3 cycles; following ADD issues on the edge after stall falls.
- hazard_detected=1 with OP_LW -> all controls 0 and flags unchanged. flush=1 with OP_JMP -> bubble.
- rst_n asserted in the second BUSY cycle -> stall=0 immediately; after release, MULT re-issues cleanly.
- OP_XOR without CTRL_EXT_OPS_EN -> illegal_op=1 and wb_en=0. With the macro defined -> exe_cmd=EXE_XOR, wb_en=1.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
//==============================================================================
// Module      : pipe_ctrl_unit_pkg
// Description : Shared opcodes, EXE commands, branch condition codes, widths,
//               control bundle type and the combinational opcode decoder for
//               the pipeline ID-stage control unit.
//               Optional macro CTRL_EXT_OPS_EN adds OR/NOR/XOR/SLA/SRA/SRL/SUBI.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package pipe_ctrl_unit_pkg;

  localparam int WORD_LEN    = 32;
  localparam int OP_CODE_LEN = 6;
  localparam int EXE_CMD_LEN = 4;

  typedef logic [OP_CODE_LEN-1:0] op_code_t;
  typedef logic [EXE_CMD_LEN-1:0] exe_cmd_t;

  // Opcodes
  localparam op_code_t OP_ADD  = 6'd1;
  localparam op_code_t OP_SUB  = 6'd3;
  localparam op_code_t OP_AND  = 6'd5;
  localparam op_code_t OP_OR   = 6'd6;
  localparam op_code_t OP_NOR  = 6'd7;
  localparam op_code_t OP_XOR  = 6'd8;
  localparam op_code_t OP_SLA  = 6'd9;
  localparam op_code_t OP_SLL  = 6'd10;
  localparam op_code_t OP_SRA  = 6'd11;
  localparam op_code_t OP_SRL  = 6'd12;
  localparam op_code_t OP_ADDI = 6'd32;
  localparam op_code_t OP_SUBI = 6'd33;
  localparam op_code_t OP_LW   = 6'd36;
  localparam op_code_t OP_SW   = 6'd37;
  localparam op_code_t OP_BNE  = 6'd40;
  localparam op_code_t OP_BEQ  = 6'd41;
  localparam op_code_t OP_BLT  = 6'd42;
  localparam op_code_t OP_JMP  = 6'd43;
  localparam op_code_t OP_CMP  = 6'd44;
  localparam op_code_t OP_CLR  = 6'd45;
  localparam op_code_t OP_MOVI = 6'd46;
  localparam op_code_t OP_MULT = 6'd47;

  // EXE commands
  localparam exe_cmd_t EXE_NO_OPERATION = 4'd0;
  localparam exe_cmd_t EXE_ADD          = 4'd1;
  localparam exe_cmd_t EXE_SUB          = 4'd2;
  localparam exe_cmd_t EXE_AND          = 4'd3;
  localparam exe_cmd_t EXE_OR           = 4'd4;
  localparam exe_cmd_t EXE_NOR          = 4'd5;
  localparam exe_cmd_t EXE_XOR          = 4'd6;
  localparam exe_cmd_t EXE_SLA          = 4'd7;
  localparam exe_cmd_t EXE_SLL          = 4'd8;
  localparam exe_cmd_t EXE_SRA          = 4'd9;
  localparam exe_cmd_t EXE_SRL          = 4'd10;
  localparam exe_cmd_t EXE_CLR          = 4'd11;
  localparam exe_cmd_t EXE_MOVI         = 4'd12;
  localparam exe_cmd_t EXE_MULT         = 4'd13;

  // Branch condition codes
  localparam logic [1:0] COND_JUMP = 2'd0;
  localparam logic [1:0] COND_BNE  = 2'd1;
  localparam logic [1:0] COND_BEQ  = 2'd2;
  localparam logic [1:0] COND_BLT  = 2'd3;

  // MULT sequencer states
  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_t;

  // Everything that lands in the ID/EXE control register
  typedef struct packed {
    exe_cmd_t   exe_cmd;
    logic [1:0] branch_cmd;
    logic       branch_en;
    logic       branch_taken;
    logic       jump_en;
    logic       is_imm;
    logic       st_or_bne;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       mult_start;
    logic       illegal_op;
  } ctrl_t;

  // Pure opcode decode; branch outcome uses the flags as currently registered.
  // CMP decodes to an all-zero bundle: its only effect is the flag write.
  function automatic ctrl_t decode_op(input op_code_t op, input logic fz, input logic fn);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.exe_cmd = EXE_ADD; c.wb_en = 1'b1; end
      OP_SUB:  begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b1; end
      OP_AND:  begin c.exe_cmd = EXE_AND; c.wb_en = 1'b1; end
      OP_SLL:  begin c.exe_cmd = EXE_SLL; c.wb_en = 1'b1; end
      OP_ADDI: begin c.exe_cmd = EXE_ADD; c.wb_en = 1'b1; c.is_imm = 1'b1; end
      OP_LW: begin
        c.exe_cmd   = EXE_ADD;
        c.wb_en     = 1'b1;
        c.is_imm    = 1'b1;
        c.st_or_bne = 1'b1;
        c.mem_r_en  = 1'b1;
      end
      OP_SW: begin
        c.exe_cmd   = EXE_NO_OPERATION;
        c.is_imm    = 1'b1;
        c.st_or_bne = 1'b1;
        c.mem_w_en  = 1'b1;
      end
      OP_CLR:  begin c.exe_cmd = EXE_CLR;  c.wb_en = 1'b1; c.is_imm = 1'b1; end
      OP_MOVI: begin c.exe_cmd = EXE_MOVI; c.wb_en = 1'b1; c.is_imm = 1'b1; end
      OP_CMP:  c = '0;
      OP_BNE: begin
        c.is_imm = 1'b1; c.branch_en = 1'b1;
        c.branch_cmd = COND_BNE; c.branch_taken = ~fz;
      end
      OP_BEQ: begin
        c.is_imm = 1'b1; c.branch_en = 1'b1;
        c.branch_cmd = COND_BEQ; c.branch_taken = fz;
      end
      OP_BLT: begin
        c.is_imm = 1'b1; c.branch_en = 1'b1;
        c.branch_cmd = COND_BLT; c.branch_taken = fn;
      end
      OP_JMP: begin
        c.is_imm = 1'b1; c.branch_en = 1'b1;
        c.branch_cmd = COND_JUMP; c.branch_taken = 1'b1; c.jump_en = 1'b1;
      end
      OP_MULT: begin c.exe_cmd = EXE_MULT; c.wb_en = 1'b1; c.mult_start = 1'b1; end
`ifdef CTRL_EXT_OPS_EN
      OP_OR:   begin c.exe_cmd = EXE_OR;  c.wb_en = 1'b1; end
      OP_NOR:  begin c.exe_cmd = EXE_NOR; c.wb_en = 1'b1; end
      OP_XOR:  begin c.exe_cmd = EXE_XOR; c.wb_en = 1'b1; end
      OP_SLA:  begin c.exe_cmd = EXE_SLA; c.wb_en = 1'b1; end
      OP_SRA:  begin c.exe_cmd = EXE_SRA; c.wb_en = 1'b1; end
      OP_SRL:  begin c.exe_cmd = EXE_SRL; c.wb_en = 1'b1; end
      OP_SUBI: begin c.exe_cmd = EXE_SUB; c.wb_en = 1'b1; c.is_imm = 1'b1; end
`endif
      default: c.illegal_op = 1'b1;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_unit_if.sv
//==============================================================================
// Module      : pipe_ctrl_unit_if
// Description : ID-stage bundle between the pipeline and the control unit:
//               instruction/hazard inputs, CMP operands, ID/EXE control
//               outputs, sequencer stall and status flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface pipe_ctrl_unit_if #(
  parameter int WORD_LEN    = pipe_ctrl_unit_pkg::WORD_LEN,
  parameter int OP_CODE_LEN = pipe_ctrl_unit_pkg::OP_CODE_LEN,
  parameter int EXE_CMD_LEN = pipe_ctrl_unit_pkg::EXE_CMD_LEN
);

  logic [OP_CODE_LEN-1:0] op_code;
  logic                   hazard_detected;
  logic                   flush;
  logic [WORD_LEN-1:0]    src1;
  logic [WORD_LEN-1:0]    src2;

  logic [EXE_CMD_LEN-1:0] exe_cmd;
  logic [1:0]             branch_cmd;
  logic                   branch_en;
  logic                   branch_taken;
  logic                   jump_en;
  logic                   is_imm;
  logic                   st_or_bne;
  logic                   wb_en;
  logic                   mem_r_en;
  logic                   mem_w_en;
  logic                   mult_start;
  logic                   stall;
  logic                   flag_z;
  logic                   flag_n;
  logic                   illegal_op;

  // Pipeline side
  modport master (
    output op_code, hazard_detected, flush, src1, src2,
    input  exe_cmd, branch_cmd, branch_en, branch_taken, jump_en, is_imm,
           st_or_bne, wb_en, mem_r_en, mem_w_en, mult_start, stall,
           flag_z, flag_n, illegal_op
  );

  // Control unit side
  modport slave (
    input  op_code, hazard_detected, flush, src1, src2,
    output exe_cmd, branch_cmd, branch_en, branch_taken, jump_en, is_imm,
           st_or_bne, wb_en, mem_r_en, mem_w_en, mult_start, stall,
           flag_z, flag_n, illegal_op
  );

endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_unit_mult_seq.sv
//==============================================================================
// Module      : ctrl_mult_seq
// Description : IDLE/BUSY sequencer that holds the front end while a
//               multi-cycle MULT occupies EXE. stall is decoded directly from
//               the state register, so it drops as soon as rst_n asserts.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module ctrl_mult_seq #(
  parameter int MULT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic stall
);
  import pipe_ctrl_unit_pkg::*;

  // Wide enough for MULT_CYCLES-1 up to 15
  localparam int CNT_W = 5;

  seq_state_t       state;
  logic [CNT_W-1:0] count;

  // A MULT occupies EXE for MULT_CYCLES edges: the issue edge plus
  // MULT_CYCLES-1 edges spent in BUSY; a single-cycle MULT never leaves IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEQ_IDLE;
      count <= '0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (start && (MULT_CYCLES > 1)) begin
            state <= SEQ_BUSY;
            count <= CNT_W'(MULT_CYCLES - 1);
          end
        end
        SEQ_BUSY: begin
          if (count <= CNT_W'(1)) begin
            state <= SEQ_IDLE;
            count <= '0;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: begin
          state <= SEQ_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign stall = (state == SEQ_BUSY);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
//==============================================================================
// Module      : pipe_ctrl_unit
// Description : ID-stage decode/control unit driving the ID/EXE control
//               register. Registered decode, Z/N flags written by CMP,
//               conditional branch resolution, MULT sequencer with front-end
//               stall, and bubble insertion on hazard/flush/busy.
//               Optional macro CTRL_EXT_OPS_EN enables the extended ALU ops.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module pipe_ctrl_unit #(
  parameter int WORD_LEN    = pipe_ctrl_unit_pkg::WORD_LEN,
  parameter int OP_CODE_LEN = pipe_ctrl_unit_pkg::OP_CODE_LEN,
  parameter int EXE_CMD_LEN = pipe_ctrl_unit_pkg::EXE_CMD_LEN,
  parameter int MULT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_ctrl_unit_if.slave bus
);
  import pipe_ctrl_unit_pkg::*;

  logic [OP_CODE_LEN-1:0] op;
  ctrl_t                  dec;
  ctrl_t                  ctrl_q;
  logic                   flag_z_q;
  logic                   flag_n_q;
  logic                   seq_busy;
  logic                   bubble;
  logic                   mult_go;
  logic                   cmp_go;
  logic [WORD_LEN:0]      cmp_diff;

  assign op = bus.op_code;

  // Decode against the flags as they stand now; a CMP in the previous slot
  // has already landed at the separating edge, so no forwarding is needed.
  always_comb begin
    dec = decode_op(op_code_t'(op), flag_z_q, flag_n_q);
  end

  // flush, BUSY and hazard all squash ID identically. flush cannot cancel an
  // in-flight MULT because the sequencer only looks at mult_go while IDLE.
  assign bubble  = bus.flush | seq_busy | bus.hazard_detected;
  assign mult_go = ~bubble & dec.mult_start;
  assign cmp_go  = ~bubble & (op == OP_CMP);

  // Sign-extended one bit wider so the subtraction cannot overflow; the top
  // bit is then the true sign of src1-src2.
  assign cmp_diff = {bus.src1[WORD_LEN-1], bus.src1} - {bus.src2[WORD_LEN-1], bus.src2};

  // Status flags change only on an accepted CMP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (cmp_go) begin
      flag_z_q <= (cmp_diff == '0);
      flag_n_q <= cmp_diff[WORD_LEN];
    end
  end

  // ID/EXE control register: decoded bundle, or all zeros for a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (bubble) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= dec;
    end
  end

  ctrl_mult_seq #(
    .MULT_CYCLES (MULT_CYCLES)
  ) u_mult_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mult_go),
    .stall (seq_busy)
  );

  assign bus.exe_cmd      = EXE_CMD_LEN'(ctrl_q.exe_cmd);
  assign bus.branch_cmd   = ctrl_q.branch_cmd;
  assign bus.branch_en    = ctrl_q.branch_en;
  assign bus.branch_taken = ctrl_q.branch_taken;
  assign bus.jump_en      = ctrl_q.jump_en;
  assign bus.is_imm       = ctrl_q.is_imm;
  assign bus.st_or_bne    = ctrl_q.st_or_bne;
  assign bus.wb_en        = ctrl_q.wb_en;
  assign bus.mem_r_en     = ctrl_q.mem_r_en;
  assign bus.mem_w_en     = ctrl_q.mem_w_en;
  assign bus.mult_start   = ctrl_q.mult_start;
  assign bus.illegal_op   = ctrl_q.illegal_op;
  assign bus.stall        = seq_busy;
  assign bus.flag_z       = flag_z_q;
  assign bus.flag_n       = flag_n_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
//==============================================================================
// Module      : tb_pipe_ctrl_unit
// Description : Self-checking bench for pipe_ctrl_unit: directed scenarios
//               plus randomized opcode/hazard/flush traffic compared against
//               a cycle-level behavioural model. Honours CTRL_EXT_OPS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_ctrl_unit;
  import pipe_ctrl_unit_pkg::*;

  localparam int MULT_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if bus ();

  pipe_ctrl_unit #(
    .MULT_CYCLES (MULT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_z, m_n;
  int          m_busy_left;
  logic [15:0] m_ctrl;

  logic [5:0] op_list [0:21] = '{OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_ADDI, OP_LW, OP_SW,
                                 OP_CLR, OP_MOVI, OP_CMP, OP_BNE, OP_BEQ, OP_BLT, OP_JMP,
                                 OP_MULT, OP_OR, OP_NOR, OP_XOR, OP_SLA, OP_SRA, OP_SRL,
                                 OP_SUBI};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs_ctrl();
    return {bus.exe_cmd, bus.branch_cmd, bus.branch_en, bus.branch_taken, bus.jump_en,
            bus.is_imm, bus.st_or_bne, bus.wb_en, bus.mem_r_en, bus.mem_w_en,
            bus.mult_start, bus.illegal_op};
  endfunction

  task automatic model_reset();
    m_z = 0; m_n = 0; m_busy_left = 0; m_ctrl = '0;
  endtask

  // One clock edge of the architectural behaviour, from the current inputs.
  task automatic model_edge();
    logic [3:0] e;
    logic [1:0] bc;
    logic ben, bt, je, imm, sob, wb, mr, mw, ms, ill;
    bit busy, is_cmp, nz, nn;
    e = EXE_NO_OPERATION; bc = 2'd0;
    {ben, bt, je, imm, sob, wb, mr, mw, ms, ill} = '0;
    busy = (m_busy_left > 0);
    is_cmp = 0; nz = m_z; nn = m_n;
    if (!(bus.flush || busy || bus.hazard_detected)) begin
      case (bus.op_code)
        OP_ADD:  begin e = EXE_ADD; wb = 1; end
        OP_SUB:  begin e = EXE_SUB; wb = 1; end
        OP_AND:  begin e = EXE_AND; wb = 1; end
        OP_SLL:  begin e = EXE_SLL; wb = 1; end
        OP_ADDI: begin e = EXE_ADD; wb = 1; imm = 1; end
        OP_LW:   begin e = EXE_ADD; wb = 1; imm = 1; sob = 1; mr = 1; end
        OP_SW:   begin imm = 1; sob = 1; mw = 1; end
        OP_CLR:  begin e = EXE_CLR; wb = 1; imm = 1; end
        OP_MOVI: begin e = EXE_MOVI; wb = 1; imm = 1; end
        OP_CMP:  begin
          is_cmp = 1;
          nz = (bus.src1 == bus.src2);
          nn = ($signed(bus.src1) < $signed(bus.src2));
        end
        OP_BNE:  begin imm = 1; ben = 1; bc = COND_BNE; bt = !m_z; end
        OP_BEQ:  begin imm = 1; ben = 1; bc = COND_BEQ; bt = m_z; end
        OP_BLT:  begin imm = 1; ben = 1; bc = COND_BLT; bt = m_n; end
        OP_JMP:  begin imm = 1; ben = 1; bc = COND_JUMP; bt = 1; je = 1; end
        OP_MULT: begin e = EXE_MULT; wb = 1; ms = 1; end
`ifdef CTRL_EXT_OPS_EN
        OP_OR:   begin e = EXE_OR;  wb = 1; end
        OP_NOR:  begin e = EXE_NOR; wb = 1; end
        OP_XOR:  begin e = EXE_XOR; wb = 1; end
        OP_SLA:  begin e = EXE_SLA; wb = 1; end
        OP_SRA:  begin e = EXE_SRA; wb = 1; end
        OP_SRL:  begin e = EXE_SRL; wb = 1; end
        OP_SUBI: begin e = EXE_SUB; wb = 1; imm = 1; end
`endif
        default: ill = 1;
      endcase
    end
    if (busy)     m_busy_left = m_busy_left - 1;
    else if (ms)  m_busy_left = MULT_CYCLES - 1;
    if (is_cmp) begin m_z = nz; m_n = nn; end
    m_ctrl = {e, bc, ben, bt, je, imm, sob, wb, mr, mw, ms, ill};
  endtask

  task automatic expect_all(input string tag);
    check_val({tag, ".ctrl"}, 32'(obs_ctrl()), 32'(m_ctrl));
    check_val({tag, ".flags"}, 32'({bus.flag_z, bus.flag_n}), 32'({m_z, m_n}));
    check_val({tag, ".stall"}, 32'(bus.stall), 32'(m_busy_left > 0));
  endtask

  // Called at a negedge: drive, step the model, check after the edge, return at the next negedge.
  task automatic apply(input logic [5:0] op, input logic hz, input logic fl,
                       input logic [31:0] a, input logic [31:0] b, input string tag);
    bus.op_code = op; bus.hazard_detected = hz; bus.flush = fl;
    bus.src1 = a; bus.src2 = b;
    model_edge();
    @(posedge clk); #1;
    expect_all(tag);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_stall;
    logic [5:0] op;
    logic [31:0] a, b;

    // Reset with ADD held in ID
    rst_n = 1'b0;
    bus.op_code = OP_ADD; bus.hazard_detected = 1'b0; bus.flush = 1'b0;
    bus.src1 = '0; bus.src2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(OP_ADD, 0, 0, 0, 0, "first");
    check_val("first.exe_cmd", 32'(bus.exe_cmd), 32'(EXE_ADD));
    check_val("first.wb_en", 32'(bus.wb_en), 32'd1);

    // CMP / conditional branch pairs
    apply(OP_CMP, 0, 0, 32'd5, 32'd7, "cmp57");
    check_val("cmp57.zn", 32'({bus.flag_z, bus.flag_n}), 32'b01);
    apply(OP_BLT, 0, 0, 0, 0, "blt");
    check_val("blt.taken", 32'(bus.branch_taken), 32'd1);
    apply(OP_CMP, 0, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, "cmpm3");
    check_val("cmpm3.z", 32'(bus.flag_z), 32'd1);
    apply(OP_BNE, 0, 0, 0, 0, "bne");
    check_val("bne.taken", 32'(bus.branch_taken), 32'd0);
    apply(OP_CMP, 0, 0, 32'h8000_0000, 32'h7FFF_FFFF, "cmpext");
    check_val("cmpext.zn", 32'({bus.flag_z, bus.flag_n}), 32'b01);

    // MULT: one-cycle start pulse, stall for MULT_CYCLES-1, ADD follows
    apply(OP_MULT, 0, 0, 0, 0, "mult");
    check_val("mult.start", 32'(bus.mult_start), 32'd1);
    n_stall = 0;
    for (int i = 0; i < 10 && bus.stall; i++) begin
      n_stall++;
      apply(OP_ADD, 0, 0, 0, 0, "mult_busy");
    end
    check_val("mult.stall_cycles", 32'(n_stall), 32'(MULT_CYCLES - 1));
    apply(OP_ADD, 0, 0, 0, 0, "after_mult");
    check_val("after_mult.exe_cmd", 32'(bus.exe_cmd), 32'(EXE_ADD));

    // Hazard and flush bubbles
    apply(OP_LW, 1, 0, 1, 2, "haz_lw");
    check_val("haz_lw.ctrl", 32'(obs_ctrl()), 32'd0);
    apply(OP_JMP, 0, 1, 0, 0, "flush_jmp");
    check_val("flush_jmp.ctrl", 32'(obs_ctrl()), 32'd0);
    apply(OP_CMP, 1, 0, 3, 3, "haz_cmp");

    // flush while BUSY does not cut the sequence short
    apply(OP_MULT, 0, 0, 0, 0, "mult2");
    apply(OP_ADD, 0, 1, 0, 0, "busy_flush");
    check_val("busy_flush.stall", 32'(bus.stall), 32'd1);
    apply(OP_ADD, 0, 0, 0, 0, "busy2");
    apply(OP_ADD, 0, 0, 0, 0, "busy3");
    apply(OP_ADD, 0, 0, 0, 0, "busy4");

    // Reset during the second BUSY cycle
    apply(OP_MULT, 0, 0, 0, 0, "mult3");
    apply(OP_ADD, 0, 0, 0, 0, "mult3_busy");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midrst.stall", 32'(bus.stall), 32'd0);
    expect_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    apply(OP_MULT, 0, 0, 0, 0, "mult_reissue");
    check_val("mult_reissue.start", 32'(bus.mult_start), 32'd1);
    for (int i = 0; i < MULT_CYCLES; i++) apply(OP_ADD, 0, 0, 0, 0, "drain");

    // Extended opcode
    apply(OP_XOR, 0, 0, 0, 0, "xor");
`ifdef CTRL_EXT_OPS_EN
    check_val("xor.exe_cmd", 32'(bus.exe_cmd), 32'(EXE_XOR));
    check_val("xor.wb_en", 32'(bus.wb_en), 32'd1);
`else
    check_val("xor.illegal", 32'(bus.illegal_op), 32'd1);
    check_val("xor.wb_en", 32'(bus.wb_en), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else                           op = op_list[$urandom_range(0, 21)];
      case ($urandom_range(0, 2))
        0:       begin a = $urandom; b = $urandom; end
        1:       begin a = 32'($signed($urandom_range(0, 8)) - 4);
                       b = 32'($signed($urandom_range(0, 8)) - 4); end
        default: begin a = $urandom; b = a; end
      endcase
      apply(op, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), a, b, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
